layer_stream_serializer: RTL

//  Parallel-to-serial bridge between neural-network layers: captures one layer's full output vector
//  (NUM_WORDS neuron outputs) in a single cycle and streams it word-by-word to the next layer.

---
 rtl/layer_stream_serializer_pkg.sv | 19 +
 rtl/layer_stream_serializer_if.sv | 31 +++
 rtl/layer_stream_serializer_sat_counter.sv | 26 ++
 rtl/layer_stream_serializer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/layer_stream_serializer_pkg.sv
// Shared types and constants for the layer stream serializer: FSM state encoding,
// default word width and per-layer vector sizes used at instantiation.
package layer_stream_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DROP_CNT_W = 8;
  localparam int LAYER1_NUM_WORDS   = 30;

  // A one-word vector still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_stream_serializer_if.sv
// Capture/stream handshake bundle between a layer and the serializer.
// slave = serializer side, master = producing layer plus downstream consumer.
interface layer_stream_serializer_if
  import layer_stream_serializer_pkg::*;
#(
  parameter int NUM_WORDS  = LAYER1_NUM_WORDS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  localparam int IDX_W = idx_width(NUM_WORDS);

  logic                            in_valid;
  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data;
  logic                            in_ready;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_last;
  logic [IDX_W-1:0]                out_index;
  logic                            out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_index
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_index
  );

endinterface

// File: rtl/layer_stream_serializer_sat_counter.sv
// Saturating event counter; an increment coincident with a clear restarts the count at one.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             s_axi_aclk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      if (clr) begin
        count <= WIDTH'(1);
      end else if (count != '1) begin
        count <= count + 1'b1;
      end
    end else if (clr) begin
      count <= '0;
    end
  end

endmodule

// File: rtl/layer_stream_serializer.sv
// Captures a full layer output vector in one cycle and streams it word by word with backpressure.
// Define LAYER_SER_DBUF_EN to add a shadow vector register for back-to-back vectors.
module layer_stream_serializer
  import layer_stream_serializer_pkg::*;
#(
  parameter int NUM_WORDS  = LAYER1_NUM_WORDS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DROP_CNT_W = DEFAULT_DROP_CNT_W
) (
  input  logic                   s_axi_aclk,
  input  logic                   reset,
  layer_stream_serializer_if.slave bus,
  output logic                   busy,
  input  logic                   clr_overrun,
  output logic                   overrun,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int               IDX_W    = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] vec_t;

  ser_state_t            state;
  vec_t                  active_vec;
  vec_t                  load_vec;
  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      index_q;
  logic [IDX_W-1:0]      next_idx;
  logic                  hs;
  logic                  last_hs;
  logic                  load_en;
  logic                  advance;
  logic                  go_idle;
  logic                  drop;

`ifdef LAYER_SER_DBUF_EN
  vec_t                  shadow_vec;
  logic                  shadow_full;
  logic                  shadow_load;
  logic                  shadow_clear;
`endif

  assign hs       = valid_q && bus.out_ready;
  assign last_hs  = hs && last_q;
  assign next_idx = index_q + 1'b1;

  always_comb begin
    load_en  = 1'b0;
    load_vec = bus.in_data;
    advance  = 1'b0;
    go_idle  = 1'b0;
    drop     = 1'b0;
`ifdef LAYER_SER_DBUF_EN
    shadow_load  = 1'b0;
    shadow_clear = 1'b0;
`endif
    case (state)
      IDLE: load_en = bus.in_valid;
      SEND: begin
        advance = hs && !last_q;
`ifdef LAYER_SER_DBUF_EN
        // On the last handshake the shadow wins, else a same-cycle vector loads directly.
        if (last_hs) begin
          if (shadow_full) begin
            load_en      = 1'b1;
            load_vec     = shadow_vec;
            shadow_clear = 1'b1;
          end else if (bus.in_valid) begin
            load_en = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
        if (bus.in_valid && !(last_hs && !shadow_full)) begin
          if (!shadow_full || last_hs) begin
            shadow_load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
`else
        go_idle = last_hs;
        drop    = bus.in_valid;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state      <= IDLE;
      active_vec <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      index_q    <= '0;
      overrun    <= 1'b0;
`ifdef LAYER_SER_DBUF_EN
      shadow_vec  <= '0;
      shadow_full <= 1'b0;
`endif
    end else begin
      if (load_en) begin
        state      <= SEND;
        active_vec <= load_vec;
        valid_q    <= 1'b1;
        data_q     <= load_vec[0];
        index_q    <= '0;
        last_q     <= (NUM_WORDS == 1);
      end else if (advance) begin
        index_q <= next_idx;
        data_q  <= active_vec[next_idx];
        last_q  <= (next_idx == LAST_IDX);
      end else if (go_idle) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
`ifdef LAYER_SER_DBUF_EN
      if (shadow_load) begin
        shadow_vec  <= bus.in_data;
        shadow_full <= 1'b1;
      end else if (shadow_clear) begin
        shadow_full <= 1'b0;
      end
`endif
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  sat_counter #(
    .WIDTH (DROP_CNT_W)
  ) u_drop_cnt (
    .s_axi_aclk (s_axi_aclk),
    .reset      (reset),
    .inc        (drop),
    .clr        (clr_overrun),
    .count      (drop_count)
  );

`ifdef LAYER_SER_DBUF_EN
  assign bus.in_ready = !shadow_full;
  assign busy         = (state == SEND) || shadow_full;
`else
  assign bus.in_ready = (state == IDLE);
  assign busy         = (state == SEND);
`endif

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_index = index_q;

endmodule
